// File: rtl/scrisc_pkg.sv
// scrisc_pkg: shared widths, ALU op encodings and control-word types for the SCRISC-16 core.
package scrisc_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int R0 = 0;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_IMM = 2'b10;
  localparam logic [1:0] ALUOP_R   = 2'b11;
  typedef struct packed {
    logic [1:0] alu_op;
    logic [4:0] funct5;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: flags a load-use hazard between the decode slot and a load sitting in EX.
module hazard_unit #(
  parameter int REG_AW = scrisc_pkg::REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);
  import scrisc_pkg::*;
  always_comb
    hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != REG_AW'(R0))
           & ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbles, stall hold, flush squash and bubble counter.
module id_ex_stage #(
  parameter int DATA_W = scrisc_pkg::DATA_W,
  parameter int REG_AW = scrisc_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic [4:0]        id_funct5,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic [4:0]        ex_funct5,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import scrisc_pkg::*;
  ctrl_t ctrl, id_ctrl;
  logic hazard;
  logic [CNT_W-1:0] cnt_next;
  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .hazard(hazard)
  );
  // Non-valid slots still carry alu_op/funct5 but can never write anything.
  always_comb begin
    id_ctrl = '{alu_op: id_alu_op, funct5: id_funct5, alu_src: id_alu_src,
                mem_read: id_mem_read, mem_write: id_mem_write,
                reg_write: id_reg_write, mem_to_reg: id_mem_to_reg};
    id_ctrl = id_valid ? id_ctrl : '{alu_op: id_alu_op, funct5: id_funct5, default: 1'b0};
    cnt_next = bubble_cnt + CNT_W'(bubble_cnt != '1);
    stall_if_id = (hazard | ext_stall) & ~flush;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ctrl        <= CTRL_BUBBLE;
      ex_valid    <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      ctrl     <= CTRL_BUBBLE;
      ex_valid <= 1'b0;
    end else if (!ext_stall) begin
      if (hazard) begin
        ctrl       <= CTRL_BUBBLE;
        ex_valid   <= 1'b0;
        bubble_cnt <= cnt_next;
      end else begin
        ctrl        <= id_ctrl;
        ex_valid    <= id_valid;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
      end
    end
  assign ex_alu_op     = ctrl.alu_op;
  assign ex_funct5     = ctrl.funct5;
  assign ex_alu_src    = ctrl.alu_src;
  assign ex_mem_read   = ctrl.mem_read;
  assign ex_mem_write  = ctrl.mem_write;
  assign ex_reg_write  = ctrl.reg_write;
  assign ex_mem_to_reg = ctrl.mem_to_reg;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the SCRISC-16 core. It sits directly upstream of the ALU control and ALU.
- Each cycle it latches the decoded control word (alu_op, funct5, enables), operands and register addresses, and presents them registered to the EX stage.
- It detects load-use hazards, inserts bubbles, honours downstream stall and branch flush, and counts hazard bubbles.

Parameters:
- DATA_W, 16, operand/immediate width
- REG_AW, 3, register address width (R0 hardwired zero)
- CNT_W, 16, width of saturating bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_alu_op  in  2  00 load/store add, 01 branch compare, 10 immediate ALU, 11 R-type (funct5 selects)
- id_funct5  in  5  R-type function field
- id_rs1, id_rs2, id_rd  in  REG_AW  source/destination register numbers
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data, id_imm  in  DATA_W  operands/immediate
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  control enables
- flush  in  1  branch taken in EX; squash the decode slot
- ext_stall  in  1  downstream (memory) busy; hold EX contents
- ex_valid  out  1  EX slot holds a real instruction
- ex_alu_op  out  2  registered id_alu_op (feeds ALU control)
- ex_funct5  out  5  registered id_funct5
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered addresses
- ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_W  registered operands
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered enables
- stall_if_id  out  1  freeze PC and IF/ID this cycle (combinational)
- bubble_cnt  out  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Reset: all ex_* outputs 0 (ex_alu_op=00, ex_funct5=0, data 0), ex_valid=0, bubble_cnt=0. Reset overrides every other input.
- Hazard is combinational: hazard = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- stall_if_id = (hazard | ext_stall) & ~flush.
- Per-edge update priority:
  1. rst
  2. flush -> bubble
  3. ext_stall -> hold all ex_* unchanged
  4. hazard -> bubble, bubble_cnt+1
  5. otherwise load all id_* into ex_*, ex_valid=id_valid
- Bubble definition: ex_valid=0, ex_alu_op=00, ex_funct5=0, all five enables 0. Address and data fields keep their previous values. Checkers must treat them as don't-care when ex_valid=0.
- id_valid=0 on a normal load: the slot is loaded with its enables forced to 0. A non-valid instruction never writes registers or memory.
- Latency: one cycle, ID to EX. A load-use hazard costs exactly one bubble, because the next cycle ex_mem_read=0 and the hazard clears.
- flush together with ext_stall: flush wins and the slot is squashed.
- flush together with hazard: flush wins, bubble_cnt does not increment, stall_if_id=0.
- ext_stall together with hazard: hold, no bubble, no count. The hazard is re-evaluated after the stall releases.
- bubble_cnt saturates at all-ones and never wraps. Only hazard bubbles count; flushes do not.
- A hazard against rd=R0 is never flagged.

Decomposition:
- Shared package scrisc_pkg holds:
  - DATA_W, REG_AW
  - ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_IMM=2'b10, ALUOP_R=2'b11
  - the bubble control-word constant
  - reg-zero constant R0=0
- One combinational sub-module, hazard_unit (load-use compare, hazard output). All registers stay in id_ex_stage.

Test Plan:
- Reset, then rst held 3 cycles with active id_* inputs -> all ex_* outputs=0, ex_valid=0, bubble_cnt=0, stall_if_id=0.
- R-type id_alu_op=11, funct5=00011, rd=2, rs1_data=0x1234 -> next cycle ex_alu_op=11, ex_funct5=00011, ex_rd=2, ex_rs1_data=0x1234, ex_valid=1.
- Load-use, part 1: load rd=3 (mem_read=1) followed by consumer with id_rs2=3, uses_rs2=1 -> stall_if_id=1 for one cycle, EX gets a bubble (ex_valid=0, enables 0), bubble_cnt=1.
- Load-use, part 2: on the next cycle the consumer enters EX with ex_rs2=3.
- Same load-use sequence with rd=0 -> no stall, bubble_cnt stays 0.
- ext_stall held 2 cycles during an R-type in EX -> ex_* unchanged both cycles, stall_if_id=1.
- flush asserted with ext_stall=1 and hazard=1 -> ex_valid=0, bubble_cnt unchanged, stall_if_id=0.
- Preload bubble_cnt near all-ones by forcing repeated hazards (CNT_W=4 build) -> count reaches 0xF and holds at 0xF.
